// File: rtl/keypad_digit_writer.sv
// Purpose : scans a 4x4 active-low matrix keypad, debounces each press and
//           emits one digit / clear / enter strobe per press (no auto-repeat).
// Latency : ROW_in is synchronised over 2 cycles; a strobe appears
//           (DEBOUNCE_SCANS-1)*SCAN_DIV+1 cycles after the detecting sample.
// Backpr. : none; strobes are single-cycle and the consumer must take them.
// Ports   : CLOCK/RESET (sync, active-high); ROW_in keypad rows (async, active-low);
//           COL_out column drive (one bit low); Digit_out + DIGIT_VALID write
//           strobe; CLEAR_PULSE on '*'; ENTER_PULSE on '#' when the barcode is
//           full; DigitsWritten digits accepted since reset/clear (0..NUM_DIGITS).
// Build   : define KEYPAD_HEX_EN to accept A..D as hex digits 0xA..0xD.
module keypad_digit_writer #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int NUM_DIGITS     = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] ROW_in,
    output logic [3:0] COL_out,
    output logic [3:0] Digit_out,
    output logic       DIGIT_VALID,
    output logic       CLEAR_PULSE,
    output logic       ENTER_PULSE,
    output logic [2:0] DigitsWritten
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [2:0]       DIGITS_MAX = 3'(NUM_DIGITS);

`ifdef KEYPAD_HEX_EN
    localparam logic HEX_IS_DIGIT = 1'b1;
`else
    localparam logic HEX_IS_DIGIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    state_t           state_q;
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       col_q;
    logic [1:0]       col_d;
    logic [1:0]       key_row_q;
    logic [1:0]       key_col_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       digit_q;
    logic             dv_q;
    logic             clr_q;
    logic             ent_q;
    logic [2:0]       written_q;

    logic       sample;
    logic       any_low;
    logic [1:0] low_row;
    logic [3:0] key_val;
    logic       key_digit;
    logic       key_clear;
    logic       key_enter;

    assign sample  = (div_q == DIV_LAST);
    assign any_low = ~&row_sync_q;
    assign div_d   = sample ? '0 : div_q + DIV_W'(1);
    assign col_d   = col_q + 2'd1;
    assign cnt_d   = cnt_q + CNT_W'(1);

    // Row 0 wins when several rows in the driven column are low.
    always_comb begin
        low_row = 2'd3;
        if (!row_sync_q[0])      low_row = 2'd0;
        else if (!row_sync_q[1]) low_row = 2'd1;
        else if (!row_sync_q[2]) low_row = 2'd2;
    end

    // Latched key -> action. Index is {row, column}.
    always_comb begin
        key_val   = 4'h0;
        key_digit = 1'b0;
        key_clear = 1'b0;
        key_enter = 1'b0;
        case ({key_row_q, key_col_q})
            4'b00_00: begin key_val = 4'h1; key_digit = 1'b1; end
            4'b00_01: begin key_val = 4'h2; key_digit = 1'b1; end
            4'b00_10: begin key_val = 4'h3; key_digit = 1'b1; end
            4'b00_11: begin key_val = 4'hA; key_digit = HEX_IS_DIGIT; end
            4'b01_00: begin key_val = 4'h4; key_digit = 1'b1; end
            4'b01_01: begin key_val = 4'h5; key_digit = 1'b1; end
            4'b01_10: begin key_val = 4'h6; key_digit = 1'b1; end
            4'b01_11: begin key_val = 4'hB; key_digit = HEX_IS_DIGIT; end
            4'b10_00: begin key_val = 4'h7; key_digit = 1'b1; end
            4'b10_01: begin key_val = 4'h8; key_digit = 1'b1; end
            4'b10_10: begin key_val = 4'h9; key_digit = 1'b1; end
            4'b10_11: begin key_val = 4'hC; key_digit = HEX_IS_DIGIT; end
            4'b11_00: key_clear = 1'b1;
            4'b11_01: begin key_val = 4'h0; key_digit = 1'b1; end
            4'b11_10: key_enter = 1'b1;
            default:  begin key_val = 4'hD; key_digit = HEX_IS_DIGIT; end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_SCAN;
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            div_q      <= '0;
            col_q      <= 2'd0;
            key_row_q  <= 2'd0;
            key_col_q  <= 2'd0;
            cnt_q      <= '0;
            digit_q    <= 4'h0;
            dv_q       <= 1'b0;
            clr_q      <= 1'b0;
            ent_q      <= 1'b0;
            written_q  <= 3'd0;
        end else begin
            row_meta_q <= ROW_in;
            row_sync_q <= row_meta_q;
            div_q      <= div_d;
            dv_q       <= 1'b0;
            clr_q      <= 1'b0;
            ent_q      <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (sample) begin
                        if (any_low) begin
                            key_row_q <= low_row;
                            key_col_q <= col_q;
                            cnt_q     <= CNT_W'(1);
                            state_q   <= (CNT_DONE == CNT_W'(1)) ? ST_EMIT : ST_DEBOUNCE;
                        end else begin
                            col_q <= col_d;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample) begin
                        if (any_low && (low_row == key_row_q)) begin
                            cnt_q <= cnt_d;
                            if (cnt_d == CNT_DONE) state_q <= ST_EMIT;
                        end else begin
                            state_q <= ST_SCAN;
                            col_q   <= col_d;
                        end
                    end
                end
                ST_EMIT: begin
                    // At most one strobe; a full barcode swallows further digits.
                    if (key_digit) begin
                        if (written_q < DIGITS_MAX) begin
                            dv_q      <= 1'b1;
                            digit_q   <= key_val;
                            written_q <= written_q + 3'd1;
                        end
                    end else if (key_clear) begin
                        clr_q     <= 1'b1;
                        written_q <= 3'd0;
                    end else if (key_enter && (written_q == DIGITS_MAX)) begin
                        ent_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Any low row restarts the release count, so a held key never repeats.
                    if (sample) begin
                        if (any_low) begin
                            cnt_q <= '0;
                        end else if (cnt_d == CNT_DONE) begin
                            cnt_q   <= '0;
                            state_q <= ST_SCAN;
                            col_q   <= col_d;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign COL_out       = ~(4'b0001 << col_q);
    assign Digit_out     = digit_q;
    assign DIGIT_VALID   = dv_q;
    assign CLEAR_PULSE   = clr_q;
    assign ENTER_PULSE   = ent_q;
    assign DigitsWritten = written_q;

endmodule

// File: tb/tb_keypad_digit_writer.sv
// Directed bench for keypad_digit_writer with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model pulls the pressed key's row low while its column is driven;
// a force path drives raw row patterns for the bounce case.
module tb_keypad_digit_writer;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] dgt;
    logic       dv;
    logic       clr;
    logic       ent;
    logic [2:0] dw;

    logic       key_en;
    logic [1:0] key_r;
    logic [1:0] key_c;
    logic       force_en;
    logic [3:0] force_val;

    int total = 0;
    int bad   = 0;

    int         dv_total    = 0;
    int         clr_total   = 0;
    int         ent_total   = 0;
    int         multi_total = 0;
    int         adj_total   = 0;
    logic [3:0] last_dig    = 4'h0;
    logic       prev_any    = 1'b0;

    int s_dv;
    int s_clr;
    int s_ent;

    keypad_digit_writer #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3),
        .NUM_DIGITS    (4)
    ) dut (
        .CLOCK        (clk),
        .RESET        (rst),
        .ROW_in       (row),
        .COL_out      (col),
        .Digit_out    (dgt),
        .DIGIT_VALID  (dv),
        .CLEAR_PULSE  (clr),
        .ENTER_PULSE  (ent),
        .DigitsWritten(dw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        if (force_en) row = force_val;
        else if (key_en && (col[key_c] == 1'b0)) row[key_r] = 1'b0;
    end

    // Strobe monitor: counts pulses and flags overlapping or back-to-back strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (dv) begin
                dv_total = dv_total + 1;
                last_dig = dgt;
            end
            if (clr) clr_total = clr_total + 1;
            if (ent) ent_total = ent_total + 1;
            if ((int'(dv) + int'(clr) + int'(ent)) > 1) multi_total = multi_total + 1;
            if ((dv || clr || ent) && prev_any) adj_total = adj_total + 1;
            prev_any = dv || clr || ent;
        end else begin
            prev_any = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r  = r;
        key_c  = c;
        key_en = 1'b1;
        repeat (60) @(negedge clk);
        key_en = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic snap();
        s_dv  = dv_total;
        s_clr = clr_total;
        s_ent = ent_total;
    endtask

    initial begin
        rst       = 1'b1;
        key_en    = 1'b0;
        key_r     = 2'd0;
        key_c     = 2'd0;
        force_en  = 1'b0;
        force_val = 4'b1111;

        // Reset values, then idle column rotation (advance on edges 4, 8, 12, 16).
        repeat (3) @(negedge clk);
        chk("rst_col", col, 4'b1110);
        chk("rst_dv", dv, 0);
        chk("rst_clr", clr, 0);
        chk("rst_ent", ent, 0);
        chk("rst_dw", dw, 0);
        chk("rst_digit", dgt, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_col_e3", col, 4'b1110);
        repeat (1) @(negedge clk);
        chk("idle_col_e4", col, 4'b1101);
        repeat (4) @(negedge clk);
        chk("idle_col_e8", col, 4'b1011);
        repeat (4) @(negedge clk);
        chk("idle_col_e12", col, 4'b0111);
        repeat (4) @(negedge clk);
        chk("idle_col_e16", col, 4'b1110);

        // Hold '5': detected on edge 8, strobe exactly on edge 17.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        key_r  = 2'd1;
        key_c  = 2'd1;
        key_en = 1'b1;
        snap();
        rst = 1'b0;
        repeat (16) @(negedge clk);
        chk("k5_early_dv", dv, 0);
        chk("k5_col_latched", col, 4'b1101);
        repeat (1) @(negedge clk);
        chk("k5_dv", dv, 1);
        chk("k5_digit", dgt, 4'h5);
        chk("k5_dw", dw, 1);
        repeat (1) @(negedge clk);
        chk("k5_dv_width", dv, 0);
        repeat (100) @(negedge clk);
        key_en = 1'b0;
        repeat (60) @(negedge clk);
        chk("k5_single_strobe", dv_total - s_dv, 1);
        chk("k5_digit_hold", dgt, 4'h5);

        // Bounce: row1 low for the edge-8 sample only.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        snap();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        force_en  = 1'b1;
        force_val = 4'b1101;
        repeat (3) @(negedge clk);
        force_val = 4'b1111;
        chk("bounce_col_held", col, 4'b1101);
        repeat (4) @(negedge clk);
        chk("bounce_col_adv", col, 4'b1011);
        force_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("bounce_no_strobe", dv_total - s_dv, 0);
        chk("bounce_dw", dw, 0);

        // Fill the barcode, overflow digit, then enter.
        snap();
        press(2'd0, 2'd0);
        press(2'd0, 2'd1);
        press(2'd0, 2'd2);
        press(2'd1, 2'd0);
        chk("fill_strobes", dv_total - s_dv, 4);
        chk("fill_dw", dw, 4);
        chk("fill_last", last_dig, 4'h4);
        press(2'd2, 2'd0);
        chk("over_strobes", dv_total - s_dv, 4);
        chk("over_dw", dw, 4);
        chk("over_digit_hold", dgt, 4'h4);
        press(2'd3, 2'd2);
        chk("enter_full", ent_total - s_ent, 1);
        chk("enter_dw", dw, 4);

        // Clear, two digits, enter refused, clear again.
        press(2'd3, 2'd0);
        chk("clear1", clr_total - s_clr, 1);
        chk("clear1_dw", dw, 0);
        press(2'd0, 2'd0);
        press(2'd0, 2'd1);
        chk("two_dw", dw, 2);
        chk("two_last", last_dig, 4'h2);
        press(2'd3, 2'd2);
        chk("enter_partial", ent_total - s_ent, 1);
        chk("enter_partial_dw", dw, 2);
        press(2'd3, 2'd0);
        chk("clear2", clr_total - s_clr, 2);
        chk("clear2_dw", dw, 0);

        // Hex key 'B'.
        snap();
        press(2'd1, 2'd3);
`ifdef KEYPAD_HEX_EN
        chk("hex_b_strobe", dv_total - s_dv, 1);
        chk("hex_b_digit", dgt, 4'hB);
        chk("hex_b_dw", dw, 1);
`else
        chk("hex_b_strobe", dv_total - s_dv, 0);
        chk("hex_b_digit", dgt, 4'h2);
        chk("hex_b_dw", dw, 0);
`endif

        // Reset while debouncing '5' aborts the press.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        key_r  = 2'd1;
        key_c  = 2'd1;
        key_en = 1'b1;
        snap();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_in_debounce", col, 4'b1101);
        rst = 1'b1;
        repeat (1) @(negedge clk);
        chk("abort_col", col, 4'b1110);
        chk("abort_dv", dv, 0);
        chk("abort_digit", dgt, 0);
        chk("abort_dw", dw, 0);
        key_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_strobe", dv_total - s_dv, 0);
        chk("abort_dw_after", dw, 0);

        chk("strobe_mutex", multi_total, 0);
        chk("strobe_adjacent", adj_total, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
